// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM states,
// and a constant-evaluable clog2 used to size the nibble index.
package adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/adder4_cin.sv
// Combinational 4-bit ripple adder with carry-in, one full-adder cell per bit.
module adder4_cin (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder: one 4-bit slice reused for WIDTH/4 cycles, LSB nibble
// first, with valid/ready handshakes on both the operand and the result side.
//
// state | meaning
// IDLE  | waiting for operands (in_ready high once out of reset)
// ADD   | one nibble per cycle through the shared slice
// DONE  | result presented, held until out_ready
module nibble_serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = clog2(NIB);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic               cout_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [NIB_W-1:0]   s4;
    logic               c4;

    adder4_cin u_slice (
        .a  (a_q[NIB_W-1:0]),
        .b  (b_q[NIB_W-1:0]),
        .ci (carry_q),
        .s  (s4),
        .co (c4)
    );

    // in_ready is a flop so it stays low while reset is asserted even though state is IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        idx_q      <= '0;
                        sum_q      <= '0;
                        cout_q     <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ADD;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                ADD: begin
                    sum_q[NIB_W*idx_q +: NIB_W] <= s4;
                    carry_q <= c4;
                    a_q     <= a_q >> NIB_W;
                    b_q     <= b_q >> NIB_W;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        cout_q      <= c4;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed and random checks of the nibble-serial adder at WIDTH 16, 8 and 32.
module tb_nibble_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv, ir, ov, ordy, cin, cout, busy;
    logic [15:0] a, b, sum;

    logic        iv8, ir8, ov8, ordy8, cin8, cout8, busy8;
    logic [7:0]  a8, b8, sum8;

    logic        iv32, ir32, ov32, ordy32, cin32, cout32, busy32;
    logic [31:0] a32, b32, sum32;

    int n_vec = 0;
    int n_bad = 0;

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .cin(cin),
        .out_valid(ov), .out_ready(ordy), .sum(sum), .cout(cout), .busy(busy));

    nibble_serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
        .out_valid(ov8), .out_ready(ordy8), .sum(sum8), .cout(cout8), .busy(busy8));

    nibble_serial_adder_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .cin(cin32),
        .out_valid(ov32), .out_ready(ordy32), .sum(sum32), .cout(cout32), .busy(busy32));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic accept16(input logic [15:0] av, input logic [15:0] bv, input logic c);
        int n;
        a = av; b = bv; cin = c; iv = 1'b1;
        n = 0;
        while (!ir && n < 30) begin tick; n++; end
        chk("accept16_ready", ir, 1);
        tick;
        iv = 1'b0;
    endtask

    task automatic wait_ov16(output int cnt);
        cnt = 0;
        while (!ov && cnt < 40) begin tick; cnt++; end
    endtask

    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic c,
                        input int stall, input string tag);
        int lat;
        logic [16:0] exp;
        exp = {1'b0, av} + {1'b0, bv} + {16'd0, c};
        ordy = 1'b0;
        accept16(av, bv, c);
        wait_ov16(lat);
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_sum"}, {cout, sum}, exp);
        for (int i = 0; i < stall; i++) tick;
        if (stall > 0) chk({tag, "_hold"}, {ov, ir, cout, sum}, {2'b10, exp});
        ordy = 1'b1;
        tick;
        ordy = 1'b0;
        chk({tag, "_hs"}, {ov, ir, busy}, 3'b010);
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic c);
        int n;
        logic [8:0] exp;
        exp = {1'b0, av} + {1'b0, bv} + {8'd0, c};
        a8 = av; b8 = bv; cin8 = c; iv8 = 1'b1; ordy8 = 1'b0;
        n = 0;
        while (!ir8 && n < 30) begin tick; n++; end
        tick;
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < 40) begin tick; n++; end
        chk("w8_lat", n, 2);
        chk("w8_sum", {cout8, sum8}, exp);
        ordy8 = 1'b1;
        tick;
        ordy8 = 1'b0;
    endtask

    task automatic op32(input logic [31:0] av, input logic [31:0] bv, input logic c);
        int n;
        logic [32:0] exp;
        exp = {1'b0, av} + {1'b0, bv} + {32'd0, c};
        a32 = av; b32 = bv; cin32 = c; iv32 = 1'b1; ordy32 = 1'b0;
        n = 0;
        while (!ir32 && n < 30) begin tick; n++; end
        tick;
        iv32 = 1'b0;
        n = 0;
        while (!ov32 && n < 40) begin tick; n++; end
        chk("w32_lat", n, 8);
        chk("w32_sum", {cout32, sum32}, exp);
        ordy32 = 1'b1;
        tick;
        ordy32 = 1'b0;
    endtask

    initial begin
        int lat;
        iv = 0; ordy = 0; a = '0; b = '0; cin = 0;
        iv8 = 0; ordy8 = 0; a8 = '0; b8 = '0; cin8 = 0;
        iv32 = 0; ordy32 = 0; a32 = '0; b32 = '0; cin32 = 0;

        #12;
        chk("reset_state", {ir, ov, busy, cout, sum}, 20'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk("ready_after_reset", ir, 1);

        op16(16'h1234, 16'h1111, 1'b0, 0, "basic");
        op16(16'hFFFF, 16'h0001, 1'b0, 0, "ripple");
        op16(16'hFFFF, 16'hFFFF, 1'b1, 0, "allones");

        // backpressure: result must stay frozen while the consumer stalls
        accept16(16'hFFFF, 16'h0001, 1'b0);
        wait_ov16(lat);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("bp_hold", {ov, ir, busy, cout, sum}, {3'b101, 17'h10000});
        end
        ordy = 1'b1;
        tick;
        ordy = 1'b0;
        chk("bp_release", {ov, ir}, 2'b01);

        // new operands offered during ADD must not disturb the running op
        accept16(16'h00F0, 16'h0F10, 1'b0);
        a = 16'hAAAA; b = 16'h5555; iv = 1'b1;
        wait_ov16(lat);
        chk("busy_in_lat", lat, 4);
        chk("busy_in_sum", {cout, sum}, 17'h01000);
        chk("busy_in_ready", ir, 0);
        ordy = 1'b1;
        tick;
        ordy = 1'b0;
        chk("busy_in_hs", {ir, busy, ov}, 3'b100);
        tick;
        chk("second_accept", {busy, ir}, 2'b10);
        iv = 1'b0;
        wait_ov16(lat);
        chk("second_sum", {cout, sum}, 17'h0FFFF);
        ordy = 1'b1;
        tick;
        ordy = 1'b0;

        // asynchronous reset mid-operation
        accept16(16'h1234, 16'h1111, 1'b0);
        tick;
        tick;
        chk("pre_reset_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 chk("mid_reset", {ov, busy, ir, cout, sum}, 20'h0);
        #3 rst_n = 1'b1;
        op16(16'h0005, 16'h0003, 1'b0, 0, "post_reset");

        for (int k = 0; k < 1000; k++) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rand16");
        end

        op8(8'hFF, 8'h01, 1'b0);
        op8(8'h5A, 8'hA5, 1'b1);
        for (int k = 0; k < 50; k++) op8(8'($urandom), 8'($urandom), 1'($urandom));

        op32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        op32(32'h1234_5678, 32'h1111_1111, 1'b1);
        for (int k = 0; k < 50; k++) op32($urandom, $urandom, 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
